// File: rtl/seg7_scan_multi_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: segment bit positions,
// hex-to-segment table and default parameter/register values.
package seg7_scan_multi_pkg;

   typedef enum int unsigned {
      SEG_A  = 0,
      SEG_B  = 1,
      SEG_C  = 2,
      SEG_D  = 3,
      SEG_E  = 4,
      SEG_F  = 5,
      SEG_G  = 6,
      SEG_DP = 7
   } seg_bit_e;

   typedef logic [7:0] seg_t;

   localparam int unsigned DEF_NDIG       = 4;
   localparam int unsigned DEF_BW         = 6;
   localparam int unsigned DEF_BBW        = 5;
   localparam int unsigned DEF_DEAD       = 2;
   localparam int unsigned DEF_TIMEOUT    = 49;
   localparam int unsigned DEF_BLINK_HALF = 15;

   // Active-high segments, bit0 = a ... bit6 = g, DP clear
   localparam seg_t HEX_SEG [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer for the digit scanner: per-slot cycle counter, digit index and
// a one-cycle frame pulse when the index wraps back to digit 0.
module seg7_slot_timer
   import seg7_scan_multi_pkg::*;
#(
   parameter int unsigned NDIG = DEF_NDIG,
   parameter int unsigned BW   = DEF_BW
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [BW-1:0]           i_timeout,
   output logic [BW-1:0]           o_tick,
   output logic [$clog2(NDIG)-1:0] o_idx,
   output logic                    o_frame
);

   localparam int unsigned IW = $clog2(NDIG);

   logic [BW-1:0] r_tick;
   logic [IW-1:0] r_idx;
   logic          r_frame;
   logic          w_slot_end;
   logic          w_last;

   // >= so a TIMEOUT lowered below the running tick ends the slot immediately
   assign w_slot_end = (r_tick >= i_timeout);
   assign w_last     = (r_idx == IW'(NDIG - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tick  <= '0;
         r_idx   <= '0;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_slot_end && w_last;
         if (w_slot_end) begin
            r_tick <= '0;
            r_idx  <= w_last ? '0 : r_idx + IW'(1);
         end else begin
            r_tick <= r_tick + BW'(1);
         end
      end
   end

   assign o_tick  = r_tick;
   assign o_idx   = r_idx;
   assign o_frame = r_frame;

endmodule

// File: rtl/seg7_scan_multi.sv
// Multiplexed NDIG-digit 7-segment scanner with dead time, PWM brightness and
// per-digit blink; registered active-high DIGIT_SEL/DIGIT outputs.
module seg7_scan_multi
   import seg7_scan_multi_pkg::*;
#(
   parameter int unsigned NDIG = DEF_NDIG,
   parameter int unsigned BW   = DEF_BW,
   parameter int unsigned BBW  = DEF_BBW,
   parameter int unsigned DEAD = DEF_DEAD
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [BW-1:0]     TIMEOUT,
   input  logic [BW-1:0]     BRIGHT,
   input  logic [BBW-1:0]    BLINK_HALF,
   input  logic [NDIG-1:0]   BLINK_EN,
   input  logic [NDIG*8-1:0] DIGITS,
   output logic [NDIG-1:0]   DIGIT_SEL,
   output logic [7:0]        DIGIT,
   output logic              FRAME
);

   localparam int unsigned   IW     = $clog2(NDIG);
   localparam logic [BW-1:0] DEAD_W = BW'(DEAD);

   logic [BW-1:0]   w_tick;
   logic [IW-1:0]   w_idx;
   logic            w_frame;
   logic [7:0]      w_pat;
   logic            w_lit;
   logic [7:0]      r_pat;
   logic [BBW-1:0]  r_fcnt;
   logic            r_blink_ph;
   logic [NDIG-1:0] r_sel;
   logic [7:0]      r_dig;

   seg7_slot_timer #(
      .NDIG (NDIG),
      .BW   (BW)
   ) u_timer (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_timeout (TIMEOUT),
      .o_tick    (w_tick),
      .o_idx     (w_idx),
      .o_frame   (w_frame)
   );

   // Pattern is sampled live on the slot's first cycle, then held for the rest of it
   assign w_pat = (w_tick == '0) ? DIGITS[8*w_idx +: 8] : r_pat;

   assign w_lit = (w_tick >= DEAD_W)
               && ((w_tick - DEAD_W) < BRIGHT)
               && !(r_blink_ph && BLINK_EN[w_idx]);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pat      <= '0;
         r_fcnt     <= '0;
         r_blink_ph <= 1'b0;
         r_sel      <= '0;
         r_dig      <= '0;
      end else begin
         r_pat <= w_pat;
         if (w_frame) begin
            if (r_fcnt >= BLINK_HALF) begin
               r_fcnt     <= '0;
               r_blink_ph <= ~r_blink_ph;
            end else begin
               r_fcnt <= r_fcnt + BBW'(1);
            end
         end
         r_sel <= w_lit ? (NDIG'(1) << w_idx) : '0;
         r_dig <= w_lit ? w_pat : '0;
      end
   end

   assign DIGIT_SEL = r_sel;
   assign DIGIT     = r_dig;
   assign FRAME     = w_frame;

   a_sel_onehot0 : assert property (@(posedge CLK) disable iff (RST) $onehot0(DIGIT_SEL));

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Directed self-checking bench for seg7_scan_multi (NDIG=4, BW=6, BBW=5, DEAD=2).
module tb_seg7_scan_multi;
   import seg7_scan_multi_pkg::*;

   localparam int unsigned NDIG = 4;
   localparam int unsigned BW   = 6;
   localparam int unsigned BBW  = 5;
   localparam int unsigned DEAD = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [BW-1:0] TIMEOUT;
   logic [BW-1:0] BRIGHT;
   logic [BBW-1:0] BLINK_HALF;
   logic [NDIG-1:0] BLINK_EN;
   logic [NDIG*8-1:0] DIGITS;
   logic [NDIG-1:0] DIGIT_SEL;
   logic [7:0]    DIGIT;
   logic          FRAME;

   int checks   = 0;
   int failures = 0;
   int kk       = 0;

   localparam logic [31:0] PATS0 = 32'h065B4F66;

   seg7_scan_multi #(
      .NDIG (NDIG),
      .BW   (BW),
      .BBW  (BBW),
      .DEAD (DEAD)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .TIMEOUT    (TIMEOUT),
      .BRIGHT     (BRIGHT),
      .BLINK_HALF (BLINK_HALF),
      .BLINK_EN   (BLINK_EN),
      .DIGITS     (DIGITS),
      .DIGIT_SEL  (DIGIT_SEL),
      .DIGIT      (DIGIT),
      .FRAME      (FRAME)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, kk, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      kk++;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_sel", 32'(DIGIT_SEL), 32'h0);
      check("rst_dig", 32'(DIGIT), 32'h0);
      check("rst_frame", 32'(FRAME), 32'h0);
      RST = 1'b0;
      kk  = 0;
   endtask

   // Expected outputs from elapsed cycles since reset release, for TIMEOUT=9 (10-cycle slots)
   task automatic run_scan(input int n, input int bright, input logic [3:0] bmask,
                           input int bhalf, input logic [31:0] pats, input string tag);
      for (int c = 0; c < n; c++) begin
         int s, t, i, f;
         logic blk, lit;
         logic [3:0] esel;
         logic [7:0] edig;
         step();
         s    = kk - 1;
         t    = s % 10;
         i    = (s / 10) % 4;
         f    = s / 40;
         blk  = ((f / (bhalf + 1)) % 2) == 1;
         lit  = (t >= 2) && ((t - 2) < bright) && !(bmask[i] && blk);
         esel = lit ? 4'(1 << i) : 4'h0;
         edig = lit ? pats[8*i +: 8] : 8'h0;
         check({tag, "_sel"}, 32'(DIGIT_SEL), 32'(esel));
         check({tag, "_dig"}, 32'(DIGIT), 32'(edig));
         check({tag, "_frame"}, 32'(FRAME), 32'((kk % 40) == 0));
      end
   endtask

   initial begin
      logic [7:0] dp_a;
      TIMEOUT    = 6'd9;
      BRIGHT     = 6'd63;
      BLINK_HALF = 5'd1;
      BLINK_EN   = 4'b0000;
      DIGITS     = PATS0;

      // Reset and full-brightness scan: 8 lit cycles per slot, FRAME every 40
      do_reset();
      run_scan(80, 63, 4'b0000, 1, PATS0, "scan");

      // PWM: 3 lit cycles per slot, then dark with scanning still running
      BRIGHT = 6'd3;
      do_reset();
      run_scan(80, 3, 4'b0000, 1, PATS0, "pwm3");
      BRIGHT = 6'd0;
      do_reset();
      run_scan(200, 0, 4'b0000, 1, PATS0, "pwm0");

      // Blink digit 2 with a 2-frame half period
      BRIGHT   = 6'd63;
      BLINK_EN = 4'b0100;
      do_reset();
      run_scan(320, 63, 4'b0100, 1, PATS0, "blink");

      // Tearing: DIGITS change during digit 1's slot
      BLINK_EN = 4'b0000;
      do_reset();
      repeat (13) step();
      check("tear_pre", 32'(DIGIT), 32'h4F);
      dp_a   = hex_to_seg(4'hA) | (8'd1 << SEG_DP);
      DIGITS = {hex_to_seg(4'h8), dp_a, hex_to_seg(4'hC), hex_to_seg(4'h0)};
      for (int c = 14; c <= 20; c++) begin
         step();
         check("tear_hold_dig", 32'(DIGIT), 32'h4F);
         check("tear_hold_sel", 32'(DIGIT_SEL), 32'h2);
      end
      step();
      check("tear_dead1", 32'(DIGIT_SEL), 32'h0);
      step();
      check("tear_dead2", 32'(DIGIT), 32'h0);
      step();
      check("tear_new_sel", 32'(DIGIT_SEL), 32'h4);
      check("tear_new_dig", 32'(DIGIT), 32'hF7);

      // TIMEOUT dropped from 49 to 5 while tick=20
      DIGITS  = PATS0;
      TIMEOUT = 6'd49;
      do_reset();
      repeat (20) step();
      check("to_long", 32'(DIGIT_SEL), 32'h1);
      TIMEOUT = 6'd5;
      step();
      check("to_k21", 32'(DIGIT_SEL), 32'h1);
      step();
      check("to_k22", 32'(DIGIT_SEL), 32'h0);
      step();
      check("to_k23", 32'(DIGIT_SEL), 32'h0);
      step();
      check("to_k24_sel", 32'(DIGIT_SEL), 32'h2);
      check("to_k24_dig", 32'(DIGIT), 32'h4F);
      repeat (3) step();
      check("to_k27", 32'(DIGIT_SEL), 32'h2);
      step();
      check("to_k28", 32'(DIGIT_SEL), 32'h0);
      repeat (2) step();
      check("to_k30", 32'(DIGIT_SEL), 32'h4);

      // Asynchronous reset while digit 2 is lit and blink phase is on
      TIMEOUT  = 6'd9;
      BLINK_EN = 4'b0001;
      do_reset();
      repeat (85) step();
      check("mid_blink_dark", 32'(DIGIT_SEL), 32'h0);
      repeat (20) step();
      check("mid_pre_sel", 32'(DIGIT_SEL), 32'h4);
      check("mid_pre_dig", 32'(DIGIT), 32'h5B);
      #2;
      RST = 1'b1;
      #1;
      check("mid_async_sel", 32'(DIGIT_SEL), 32'h0);
      check("mid_async_dig", 32'(DIGIT), 32'h0);
      check("mid_async_frame", 32'(FRAME), 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      kk  = 0;
      repeat (2) step();
      check("mid_resume_dead", 32'(DIGIT_SEL), 32'h0);
      step();
      check("mid_resume_sel", 32'(DIGIT_SEL), 32'h1);
      check("mid_resume_dig", 32'(DIGIT), 32'h66);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
